// File: rtl/multi_lane_judge_pkg.sv
// Shared grade encodings, point values and small helpers for multi_lane_judge.
// Optional debounce is enabled with JUDGE_DEBOUNCE_EN.
package multi_lane_judge_pkg;

    typedef enum logic [1:0] {
        GRADE_NONE    = 2'd0,
        GRADE_MISS    = 2'd1,
        GRADE_GOOD    = 2'd2,
        GRADE_PERFECT = 2'd3
    } grade_e;

    localparam logic [1:0] PTS_GOOD    = 2'd1;
    localparam logic [1:0] PTS_PERFECT = 2'd2;

    // Base points per event: up to 8 lanes x 2 points.
    localparam int HIT_CNT_W = 4;
    localparam int EVT_PTS_W = 5;
    localparam int PTS_W     = 6;

    function automatic logic [HIT_CNT_W-1:0] count_ones8(input logic [7:0] v);
        logic [HIT_CNT_W-1:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/multi_lane_judge_if.sv
// Game-side bus of the hit judge: lane inputs, scroll timing, grades and score.
interface multi_lane_judge_if #(
    parameter int LANES    = 2,
    parameter int OFFSET_W = 3,
    parameter int SCORE_W  = 16,
    parameter int COMBO_W  = 8
);
    logic                  start;
    logic                  game_active;
    logic [LANES-1:0]      button;
    logic [LANES-1:0]      note_at_judge;
    logic [OFFSET_W-1:0]   offset;
    logic                  step;
    logic [LANES-1:0]      delete;
    logic [2*LANES-1:0]    grade;
    logic [LANES-1:0]      grade_vld;
    logic [SCORE_W-1:0]    score;
    logic [COMBO_W-1:0]    combo;
    logic [COMBO_W-1:0]    max_combo;

    modport master (
        output start, game_active, button, note_at_judge, offset, step,
        input  delete, grade, grade_vld, score, combo, max_combo
    );

    modport slave (
        input  start, game_active, button, note_at_judge, offset, step,
        output delete, grade, grade_vld, score, combo, max_combo
    );
endinterface

// File: rtl/lane_input_cond.sv
// One lane button: 2-FF synchroniser, optional debounce (JUDGE_DEBOUNCE_EN),
// rising-edge detect producing a single-cycle press.
module lane_input_cond
`ifdef JUDGE_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYC = 65536
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic press
);

    logic [1:0] sync_r;
    logic       level_s;
    logic       prev_r;

    // Bring the raw asynchronous button into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], button};
        end
    end

`ifdef JUDGE_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic [CNT_W-1:0] cnt_r;
    logic             stable_r;

    // Accept a new level only after it has held for DEBOUNCE_CYC cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= {CNT_W{1'b0}};
            stable_r <= 1'b0;
        end else if (sync_r[1] == stable_r) begin
            cnt_r    <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_W'(DEBOUNCE_CYC - 1)) begin
            cnt_r    <= {CNT_W{1'b0}};
            stable_r <= sync_r[1];
        end else begin
            cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign level_s = stable_r;
`else
    assign level_s = sync_r[1];
`endif

    // Previous level for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= level_s;
        end
    end

    assign press = level_s & ~prev_r;

endmodule

// File: rtl/multi_lane_judge.sv
// N-lane hit judge: grades presses against the judge row, detects misses on
// scroll steps, keeps saturating score/combo/max_combo. Debounce: JUDGE_DEBOUNCE_EN.
module multi_lane_judge
    import multi_lane_judge_pkg::*;
#(
    parameter int LANES        = 2,
    parameter int OFFSET_W     = 3,
    parameter int PERFECT_LO   = 2,
    parameter int PERFECT_HI   = 5,
    parameter int SCORE_W      = 16,
    parameter int COMBO_W      = 8,
    parameter int BONUS_TH     = 50,
    parameter int DEBOUNCE_CYC = 65536
) (
    input  logic                 clk,
    input  logic                 rst,
    multi_lane_judge_if.slave    bus
);

    if (LANES < 1 || LANES > 8 || PERFECT_LO > PERFECT_HI || DEBOUNCE_CYC < 1) begin : g_bad_cfg
        $error("multi_lane_judge: unsupported parameter set");
    end

    logic [LANES-1:0]      press_s;
    logic [LANES-1:0]      hit_s;
    logic [LANES-1:0]      miss_s;
    logic                  perfect_s;
    logic [HIT_CNT_W-1:0]  hit_cnt_s;
    logic [EVT_PTS_W-1:0]  pts_base_s;
    logic [2*LANES-1:0]    grade_nxt_s;
    logic [PTS_W-1:0]      pts_eff_s;
    logic [SCORE_W:0]      score_sum_s;
    logic [SCORE_W-1:0]    score_nxt_s;
    logic [COMBO_W:0]      combo_sum_s;
    logic [COMBO_W-1:0]    combo_nxt_s;

    logic [LANES-1:0]      judged_r;
    logic [LANES-1:0]      delete_r;
    logic [LANES-1:0]      grade_vld_r;
    logic [2*LANES-1:0]    grade_r;
    logic [EVT_PTS_W-1:0]  evt_pts_r;
    logic [HIT_CNT_W-1:0]  evt_hits_r;
    logic                  evt_miss_r;
    logic [SCORE_W-1:0]    score_r;
    logic [COMBO_W-1:0]    combo_r;
    logic [COMBO_W-1:0]    max_combo_r;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
`ifdef JUDGE_DEBOUNCE_EN
        lane_input_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cond (
`else
        lane_input_cond u_cond (
`endif
            .clk    (clk),
            .rst    (rst),
            .button (bus.button[g]),
            .press  (press_s[g])
        );
    end

    // Judge: offset is shared by all lanes, so every hit this cycle has one grade.
    always_comb begin
        hit_s       = {LANES{1'b0}};
        miss_s      = {LANES{1'b0}};
        grade_nxt_s = grade_r;
        perfect_s   = (bus.offset >= OFFSET_W'(PERFECT_LO)) &&
                      (bus.offset <= OFFSET_W'(PERFECT_HI));
        for (int i = 0; i < LANES; i++) begin
            hit_s[i]  = press_s[i] & bus.note_at_judge[i] & ~judged_r[i] &
                        bus.game_active & ~bus.start;
            miss_s[i] = bus.step & bus.note_at_judge[i] & ~judged_r[i] & ~hit_s[i] &
                        bus.game_active & ~bus.start;
            if (hit_s[i]) begin
                grade_nxt_s[2*i +: 2] = perfect_s ? GRADE_PERFECT : GRADE_GOOD;
            end else if (miss_s[i]) begin
                grade_nxt_s[2*i +: 2] = GRADE_MISS;
            end else begin
                grade_nxt_s[2*i +: 2] = grade_r[2*i +: 2];
            end
        end
        hit_cnt_s  = count_ones8(8'(hit_s));
        pts_base_s = EVT_PTS_W'(hit_cnt_s) *
                     EVT_PTS_W'(perfect_s ? PTS_PERFECT : PTS_GOOD);
    end

    // Apply the previous cycle's event; bonus uses combo before this update.
    always_comb begin
        if (int'(combo_r) >= BONUS_TH) begin
            pts_eff_s = {evt_pts_r, 1'b0};
        end else begin
            pts_eff_s = {1'b0, evt_pts_r};
        end
        score_sum_s = {1'b0, score_r} + (SCORE_W+1)'(pts_eff_s);
        if (score_sum_s[SCORE_W]) begin
            score_nxt_s = {SCORE_W{1'b1}};
        end else begin
            score_nxt_s = score_sum_s[SCORE_W-1:0];
        end
        combo_sum_s = {1'b0, combo_r} + (COMBO_W+1)'(evt_hits_r);
        if (evt_miss_r) begin
            combo_nxt_s = {COMBO_W{1'b0}};
        end else if (combo_sum_s[COMBO_W]) begin
            combo_nxt_s = {COMBO_W{1'b1}};
        end else begin
            combo_nxt_s = combo_sum_s[COMBO_W-1:0];
        end
    end

    // Judge pulses, judged flags, pending event and the score counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            judged_r    <= {LANES{1'b0}};
            delete_r    <= {LANES{1'b0}};
            grade_vld_r <= {LANES{1'b0}};
            grade_r     <= {(2*LANES){1'b0}};
            evt_pts_r   <= {EVT_PTS_W{1'b0}};
            evt_hits_r  <= {HIT_CNT_W{1'b0}};
            evt_miss_r  <= 1'b0;
            score_r     <= {SCORE_W{1'b0}};
            combo_r     <= {COMBO_W{1'b0}};
            max_combo_r <= {COMBO_W{1'b0}};
        end else if (bus.start) begin
            judged_r    <= {LANES{1'b0}};
            delete_r    <= {LANES{1'b0}};
            grade_vld_r <= {LANES{1'b0}};
            evt_pts_r   <= {EVT_PTS_W{1'b0}};
            evt_hits_r  <= {HIT_CNT_W{1'b0}};
            evt_miss_r  <= 1'b0;
            score_r     <= {SCORE_W{1'b0}};
            combo_r     <= {COMBO_W{1'b0}};
            max_combo_r <= {COMBO_W{1'b0}};
        end else begin
            // A hit in the step cycle judges the outgoing note, so the flag need not survive.
            judged_r    <= bus.step ? {LANES{1'b0}} : (judged_r | hit_s);
            delete_r    <= hit_s;
            grade_vld_r <= hit_s | miss_s;
            grade_r     <= grade_nxt_s;
            evt_pts_r   <= pts_base_s;
            evt_hits_r  <= hit_cnt_s;
            evt_miss_r  <= |miss_s;
            score_r     <= score_nxt_s;
            combo_r     <= combo_nxt_s;
            max_combo_r <= (combo_r > max_combo_r) ? combo_r : max_combo_r;
        end
    end

    assign bus.delete    = delete_r;
    assign bus.grade_vld = grade_vld_r;
    assign bus.grade     = grade_r;
    assign bus.score     = score_r;
    assign bus.combo     = combo_r;
    assign bus.max_combo = max_combo_r;

endmodule

// File: tb/tb_multi_lane_judge.sv
// Directed bench for multi_lane_judge: vector table for single press events,
// hand sequences for misses, bonus, saturation, reset and start.
module tb_multi_lane_judge;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    multi_lane_judge_if #(.LANES(2), .OFFSET_W(3), .SCORE_W(8), .COMBO_W(8)) bus ();

    multi_lane_judge #(
        .LANES(2), .OFFSET_W(3), .PERFECT_LO(2), .PERFECT_HI(5),
        .SCORE_W(8), .COMBO_W(8), .BONUS_TH(50), .DEBOUNCE_CYC(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0] btn;
        logic [1:0] note;
        logic [2:0] off;
        logic       keep;
        logic [1:0] exp_del;
        logic [1:0] exp_vld;
        logic [3:0] exp_grade;
        logic [7:0] exp_score;
        logic [7:0] exp_combo;
        logic [7:0] exp_max;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_step();
        @(posedge clk); #1;
        bus.step = 1'b1;
        @(posedge clk); #1;
        bus.step = 1'b0;
    endtask

    // Press with a note present, release, clear the row and step to reset judged flags.
    task automatic hit_event(input logic [1:0] mask, input logic [1:0] note, input logic [2:0] off);
        @(posedge clk); #1;
        bus.note_at_judge = note;
        bus.offset        = off;
        bus.button        = mask;
        repeat (4) @(posedge clk);
        #1;
        bus.button        = 2'b00;
        bus.note_at_judge = 2'b00;
        repeat (2) @(posedge clk);
        pulse_step();
        repeat (2) @(posedge clk);
    endtask

    task automatic chk_counters(input string tag, input logic [7:0] s, input logic [7:0] c, input logic [7:0] m);
        @(negedge clk);
        chk({tag, " score"}, 32'(bus.score), 32'(s));
        chk({tag, " combo"}, 32'(bus.combo), 32'(c));
        chk({tag, " max_combo"}, 32'(bus.max_combo), 32'(m));
    endtask

    initial begin
        //            btn    note   off   keep  del    vld    grade    score  combo  max
        vecs[0] = '{2'b01, 2'b01, 3'd3, 1'b0, 2'b01, 2'b01, 4'b0011, 8'd2,  8'd1,  8'd1};
        vecs[1] = '{2'b10, 2'b10, 3'd7, 1'b1, 2'b10, 2'b10, 4'b1011, 8'd3,  8'd2,  8'd2};
        vecs[2] = '{2'b10, 2'b10, 3'd3, 1'b0, 2'b00, 2'b00, 4'b1011, 8'd3,  8'd2,  8'd2};
        vecs[3] = '{2'b01, 2'b00, 3'd3, 1'b0, 2'b00, 2'b00, 4'b1011, 8'd3,  8'd2,  8'd2};
        vecs[4] = '{2'b11, 2'b11, 3'd2, 1'b0, 2'b11, 2'b11, 4'b1111, 8'd7,  8'd4,  8'd4};
        vecs[5] = '{2'b11, 2'b11, 3'd5, 1'b0, 2'b11, 2'b11, 4'b1111, 8'd11, 8'd6,  8'd6};
        vecs[6] = '{2'b01, 2'b01, 3'd1, 1'b0, 2'b01, 2'b01, 4'b1110, 8'd12, 8'd7,  8'd7};
        vecs[7] = '{2'b11, 2'b01, 3'd6, 1'b0, 2'b01, 2'b01, 4'b1110, 8'd13, 8'd8,  8'd8};
        vecs[8] = '{2'b01, 2'b01, 3'd0, 1'b0, 2'b01, 2'b01, 4'b1110, 8'd14, 8'd9,  8'd9};

        rst               = 1'b1;
        bus.start         = 1'b0;
        bus.game_active   = 1'b1;
        bus.button        = 2'b00;
        bus.note_at_judge = 2'b00;
        bus.offset        = 3'd0;
        bus.step          = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset score", 32'(bus.score), 32'd0);
        chk("reset combo", 32'(bus.combo), 32'd0);
        chk("reset grade", 32'(bus.grade), 32'd0);
        chk("reset delete", 32'(bus.delete), 32'd0);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;

        for (int v = 0; v < 9; v++) begin
            @(posedge clk); #1;
            bus.note_at_judge = vecs[v].note;
            bus.offset        = vecs[v].off;
            bus.button        = vecs[v].btn;
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d delete early", v), 32'(bus.delete), 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d delete", v), 32'(bus.delete), 32'(vecs[v].exp_del));
            chk($sformatf("v%0d grade_vld", v), 32'(bus.grade_vld), 32'(vecs[v].exp_vld));
            chk($sformatf("v%0d grade", v), 32'(bus.grade), 32'(vecs[v].exp_grade));
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d delete width", v), 32'(bus.delete), 32'd0);
            chk($sformatf("v%0d score", v), 32'(bus.score), 32'(vecs[v].exp_score));
            chk($sformatf("v%0d combo", v), 32'(bus.combo), 32'(vecs[v].exp_combo));
            @(posedge clk); #1;
            bus.button = 2'b00;
            @(negedge clk);
            chk($sformatf("v%0d max_combo", v), 32'(bus.max_combo), 32'(vecs[v].exp_max));
            repeat (3) @(posedge clk);
            if (!vecs[v].keep) begin
                #1;
                bus.note_at_judge = 2'b00;
                pulse_step();
                repeat (2) @(posedge clk);
            end
        end

        // Unjudged note at step: MISS one cycle later, no delete, combo cleared.
        @(posedge clk); #1;
        bus.note_at_judge = 2'b01;
        bus.step          = 1'b1;
        @(posedge clk); #1;
        bus.step          = 1'b0;
        bus.note_at_judge = 2'b00;
        @(negedge clk);
        chk("miss grade_vld", 32'(bus.grade_vld), 32'd1);
        chk("miss grade", 32'(bus.grade), 32'b1101);
        chk("miss delete", 32'(bus.delete), 32'd0);
        @(posedge clk);
        chk_counters("miss", 8'd14, 8'd0, 8'd9);

        // Press on lane 1 in the step cycle while lane 0 misses: hit scores, combo stays 0.
        repeat (2) @(posedge clk);
        #1;
        bus.note_at_judge = 2'b11;
        bus.offset        = 3'd7;
        bus.button        = 2'b10;
        repeat (2) @(posedge clk);
        #1;
        bus.step = 1'b1;
        @(posedge clk); #1;
        bus.step          = 1'b0;
        bus.note_at_judge = 2'b00;
        @(negedge clk);
        chk("mixed grade_vld", 32'(bus.grade_vld), 32'd3);
        chk("mixed delete", 32'(bus.delete), 32'd2);
        chk("mixed grade", 32'(bus.grade), 32'b1001);
        @(posedge clk);
        chk_counters("mixed", 8'd15, 8'd0, 8'd9);
        #1;
        bus.button = 2'b00;
        repeat (4) @(posedge clk);

        // Build combo to 49 with GOOD hits, then cross the bonus threshold.
        repeat (24) hit_event(2'b11, 2'b11, 3'd7);
        hit_event(2'b01, 2'b01, 3'd7);
        chk_counters("combo49", 8'd64, 8'd49, 8'd49);
        hit_event(2'b11, 2'b11, 3'd3);
        chk_counters("bonus edge", 8'd68, 8'd51, 8'd51);
        hit_event(2'b10, 2'b10, 3'd4);
        chk_counters("bonus", 8'd72, 8'd52, 8'd52);

        // Drive score into saturation with doubled PERFECT pairs.
        repeat (22) hit_event(2'b11, 2'b11, 3'd3);
        chk_counters("near sat", 8'd248, 8'd96, 8'd96);
        hit_event(2'b11, 2'b11, 3'd3);
        chk_counters("sat", 8'd255, 8'd98, 8'd98);
        hit_event(2'b11, 2'b11, 3'd3);
        chk_counters("sat hold", 8'd255, 8'd100, 8'd100);

        // Asynchronous reset mid-combo clears outputs before the next edge.
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        chk("async rst score", 32'(bus.score), 32'd0);
        chk("async rst combo", 32'(bus.combo), 32'd0);
        chk("async rst max_combo", 32'(bus.max_combo), 32'd0);
        chk("async rst grade", 32'(bus.grade), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Inactive game: no hit and no miss.
        bus.game_active = 1'b0;
        hit_event(2'b01, 2'b01, 3'd3);
        chk_counters("inactive hit", 8'd0, 8'd0, 8'd0);
        @(posedge clk); #1;
        bus.note_at_judge = 2'b01;
        bus.step          = 1'b1;
        @(posedge clk); #1;
        bus.step          = 1'b0;
        bus.note_at_judge = 2'b00;
        @(negedge clk);
        chk("inactive miss vld", 32'(bus.grade_vld), 32'd0);
        chk("inactive grade", 32'(bus.grade), 32'd0);
        bus.game_active = 1'b1;

        // start clears score, combo and max_combo on the next cycle.
        hit_event(2'b01, 2'b01, 3'd3);
        chk_counters("pre start", 8'd2, 8'd1, 8'd1);
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk_counters("start", 8'd0, 8'd0, 8'd0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
